audio_playback_ctrl: RTL

- Sequences the flash sample reader for audio playback.
- Generates the sample-rate tick and paces the reader through its data-ready/confirm handshake.
- Owns play/pause, direction, restart and playback speed.
- Sits between keyboard command decode (one-cycle pulses) and the audio codec sample interface, on the 50 MHz clk.

---
 rtl/audio_playback_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/audio_playback_ctrl.sv
// rtl/audio_playback_ctrl.sv - Playback sequencer: sample tick, reader handshake, transport and speed control
// Divider speed control (faster/slower) is built only when SPEED_CTRL_EN is defined.
module audio_playback_ctrl #(
    parameter int DEFAULT_DIV = 2272,
    parameter int MIN_DIV     = 64,
    parameter int MAX_DIV     = 8192,
    parameter int DIV_STEP    = 128,
    parameter int RST_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_play,
    input  logic        cmd_pause,
    input  logic        cmd_fwd,
    input  logic        cmd_bwd,
    input  logic        cmd_restart,
    input  logic        cmd_faster,
    input  logic        cmd_slower,
    input  logic [15:0] rd_sample,
    input  logic        rd_ready,
    output logic        rd_confirm,
    output logic        rd_direction,
    output logic        rd_rst,
    output logic [15:0] audio_sample,
    output logic        audio_strobe,
    output logic        playing,
    output logic [15:0] div_value,
    output logic [7:0]  underrun_cnt
);

    localparam logic [15:0] DIV_RST   = 16'(DEFAULT_DIV);
    localparam logic [7:0]  RCNT_LAST = 8'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_PAUSED  = 2'd0,
        ST_PLAY    = 2'd1,
        ST_RESTART = 2'd2
    } state_t;

    state_t      state_q, state_d;
    state_t      ret_q, ret_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  rcnt_q, rcnt_d;
    logic        dir_q, dir_d;
    logic        confirm_q, confirm_d;
    logic        strobe_q, strobe_d;
    logic [15:0] sample_q, sample_d;
    logic [7:0]  under_q, under_d;
    logic [15:0] div_cur;
    logic        tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_PAUSED;
            ret_q     <= ST_PAUSED;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            dir_q     <= 1'b1;
            confirm_q <= 1'b0;
            strobe_q  <= 1'b0;
            sample_q  <= '0;
            under_q   <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            dir_q     <= dir_d;
            confirm_q <= confirm_d;
            strobe_q  <= strobe_d;
            sample_q  <= sample_d;
            under_q   <= under_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        cnt_d    = cnt_q;
        rcnt_d   = rcnt_q;
        dir_d    = dir_q;
        sample_d = sample_q;
        under_d  = under_q;
        tick     = 1'b0;

        case (state_q)
            ST_PAUSED: begin
                if (cmd_restart) begin
                    state_d = ST_RESTART;
                    ret_d   = ST_PAUSED;
                    rcnt_d  = '0;
                    cnt_d   = '0;
                end else if (cmd_play && !cmd_pause) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // The cycle that leaves PLAY never ticks, so no confirm can trail into PAUSED or RESTART.
                if (cmd_restart) begin
                    state_d = ST_RESTART;
                    ret_d   = ST_PLAY;
                    rcnt_d  = '0;
                    cnt_d   = '0;
                end else if (cmd_pause) begin
                    state_d = ST_PAUSED;
                end else if (cnt_q >= div_cur - 16'd1) begin
                    cnt_d = '0;
                    tick  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESTART: begin
                cnt_d = '0;
                if (rcnt_q == RCNT_LAST) begin
                    state_d = ret_q;
                end else begin
                    rcnt_d = rcnt_q + 8'd1;
                end
            end
            default: state_d = ST_PAUSED;
        endcase

        if (state_q != ST_RESTART && (cmd_fwd != cmd_bwd)) begin
            dir_d = cmd_fwd;
        end

        strobe_d  = tick;
        confirm_d = tick && rd_ready;
        if (tick && rd_ready) begin
            sample_d = rd_sample;
        end
        if (tick && !rd_ready && under_q != 8'hFF) begin
            under_d = under_q + 8'd1;
        end
    end

`ifdef SPEED_CTRL_EN
    logic [15:0] div_q, div_d;
    logic [15:0] pend_q, pend_d;
    logic [16:0] pend_up;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= DIV_RST;
            pend_q <= DIV_RST;
        end else begin
            div_q  <= div_d;
            pend_q <= pend_d;
        end
    end

    // Pending value absorbs back-to-back commands; it reaches the live divider only at a wrap while playing.
    always_comb begin
        pend_d  = pend_q;
        pend_up = {1'b0, pend_q} + 17'(DIV_STEP);
        if (state_q != ST_RESTART) begin
            if (cmd_faster && !cmd_slower) begin
                if ({1'b0, pend_q} <= 17'(MIN_DIV + DIV_STEP)) begin
                    pend_d = 16'(MIN_DIV);
                end else begin
                    pend_d = pend_q - 16'(DIV_STEP);
                end
            end else if (cmd_slower && !cmd_faster) begin
                pend_d = (pend_up > 17'(MAX_DIV)) ? 16'(MAX_DIV) : pend_up[15:0];
            end
        end
        div_d = div_q;
        if (state_q != ST_PLAY || tick) begin
            div_d = pend_d;
        end
    end

    assign div_cur = div_q;
`else
    logic unused_speed;
    assign unused_speed = cmd_faster ^ cmd_slower;
    assign div_cur      = DIV_RST;
`endif

    assign rd_confirm   = confirm_q;
    assign rd_direction = dir_q;
    assign rd_rst       = (state_q == ST_RESTART);
    assign audio_sample = sample_q;
    assign audio_strobe = strobe_q;
    assign playing      = (state_q == ST_PLAY);
    assign div_value    = div_cur;
    assign underrun_cnt = under_q;

endmodule
